// File: rtl/lb_app_capture_pkg.sv
// rtl/lb_app_capture_pkg.sv - shared offsets, control bits and state encodings for lb_app_capture
package lb_app_capture_pkg;

   localparam logic [19:0] OFF_CTRL = 20'h10000;
   localparam logic [19:0] OFF_PTC  = 20'h10001;
   localparam logic [19:0] OFF_TPTR = 20'h10002;
   localparam logic [19:0] OFF_CNT  = 20'h10003;
   localparam logic [19:0] OFF_BUF  = 20'h18000;

   localparam int CTRL_ARM   = 0;
   localparam int CTRL_FORCE = 1;
   localparam int CTRL_CLEAR = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARMED     = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } cap_state_t;

endpackage

// File: rtl/dpram.sv
// rtl/dpram.sv - simple dual-port RAM, one write port, one registered read-first read port
module dpram #(
   parameter int aw = 10,
   parameter int dw = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [aw-1:0] waddr,
   input  logic [dw-1:0] wdata,
   input  logic [aw-1:0] raddr,
   output logic [dw-1:0] rdata
);

   logic [dw-1:0] mem [0:(1<<aw)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/lb_app_capture.sv
// rtl/lb_app_capture.sv - pre/post-trigger sample capture with localbus control and readback
module lb_app_capture
   import lb_app_capture_pkg::*;
#(
   parameter int aw = 10,
   parameter int dw = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [23:0]   lb_addr,
   input  logic          lb_strobe,
   input  logic          lb_rd,
   input  logic [31:0]   lb_data_out,
   output logic [31:0]   lb_data_in,
   input  logic [dw-1:0] sample_data,
   input  logic          sample_valid,
   input  logic          trig_ext,
   output logic          busy,
   output logic          done
);

   localparam logic [aw-1:0] PTC_MAX = '1;
   localparam logic [aw:0]   N_W     = {1'b1, {aw{1'b0}}};

   cap_state_t    state_q, state_d;
   logic [aw-1:0] wptr_q, fill_q, ptc_q, ptc_act_q, trig_ptr_q;
   logic [aw:0]   post_q;
   logic [31:0]   sample_cnt_q;
   logic          trig_seen_q, trig_q;

   logic [19:0]   off;
   logic          win, wr, wr_ctrl, wr_ptc;
   logic          arm, force_trig, clear, trig_evt;
   logic          mem_we, accept_trig;
   logic [aw-1:0] ptc_sat, rd_addr;
   logic [aw:0]   post_init;
   logic [31:0]   reg_val, rd_reg_q;
   logic          rd_buf_q;
   logic [dw-1:0] ram_q;

   assign off        = lb_addr[19:0];
   assign win        = (lb_addr[23:20] == 4'h1) && lb_addr[16];
   assign wr         = lb_strobe && !lb_rd && win;
   assign wr_ctrl    = wr && (off == OFF_CTRL);
   assign wr_ptc     = wr && (off == OFF_PTC);
   assign clear      = wr_ctrl && lb_data_out[CTRL_CLEAR];
   assign arm        = wr_ctrl && lb_data_out[CTRL_ARM] && !clear;
   assign force_trig = wr_ctrl && lb_data_out[CTRL_FORCE];
   assign trig_evt   = force_trig || (trig_ext && !trig_q);
   assign ptc_sat    = (lb_data_out > 32'(PTC_MAX)) ? PTC_MAX : lb_data_out[aw-1:0];
   assign post_init  = N_W - {1'b0, ptc_act_q};

   assign busy = (state_q == ST_ARMED) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
   assign done = (state_q == ST_DONE);

   // The trigger sample itself counts as the first post-trigger sample.
   always_comb begin
      state_d     = state_q;
      mem_we      = 1'b0;
      accept_trig = 1'b0;
      case (state_q)
         ST_ARMED: begin
            mem_we = sample_valid;
            if ((ptc_act_q == '0) || (sample_valid && (fill_q + aw'(1) == ptc_act_q)))
               state_d = ST_WAIT_TRIG;
         end
         ST_WAIT_TRIG: begin
            mem_we = sample_valid;
            if (trig_evt) begin
               accept_trig = 1'b1;
               if (sample_valid && (post_init == (aw+1)'(1))) state_d = ST_DONE;
               else                                            state_d = ST_POST;
            end
         end
         ST_POST: begin
            mem_we = sample_valid;
            if (sample_valid && (post_q == (aw+1)'(1))) state_d = ST_DONE;
         end
         default: ;
      endcase
      if (arm) begin
         mem_we      = 1'b0;
         accept_trig = 1'b0;
         state_d     = (ptc_q == '0) ? ST_WAIT_TRIG : ST_ARMED;
      end
      if (clear) begin
         mem_we      = 1'b0;
         accept_trig = 1'b0;
         state_d     = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         wptr_q       <= '0;
         fill_q       <= '0;
         ptc_q        <= '0;
         ptc_act_q    <= '0;
         trig_ptr_q   <= '0;
         post_q       <= '0;
         sample_cnt_q <= '0;
         trig_seen_q  <= 1'b0;
         trig_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         trig_q  <= trig_ext;
         if (wr_ptc) ptc_q <= ptc_sat;
         if (clear) begin
            trig_seen_q <= 1'b0;
         end else if (arm) begin
            wptr_q       <= '0;
            fill_q       <= '0;
            ptc_act_q    <= ptc_q;
            sample_cnt_q <= '0;
            trig_seen_q  <= 1'b0;
         end else begin
            if (mem_we) begin
               wptr_q       <= wptr_q + aw'(1);
               sample_cnt_q <= sample_cnt_q + 32'd1;
               if (state_q == ST_ARMED) fill_q <= fill_q + aw'(1);
            end
            if (accept_trig) begin
               trig_ptr_q  <= wptr_q;
               trig_seen_q <= 1'b1;
               post_q      <= sample_valid ? post_init - (aw+1)'(1) : post_init;
            end else if ((state_q == ST_POST) && sample_valid) begin
               post_q <= post_q - (aw+1)'(1);
            end
         end
      end
   end

   assign rd_addr = trig_ptr_q - ptc_act_q + off[aw-1:0];

   dpram #(.aw(aw), .dw(dw)) u_buf (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wptr_q),
      .wdata (sample_data),
      .raddr (rd_addr),
      .rdata (ram_q)
   );

   always_comb begin
      reg_val = 32'd0;
      if (win) begin
         case (off)
            OFF_CTRL: reg_val = {28'd0, state_q, trig_seen_q};
            OFF_PTC:  reg_val = 32'(ptc_q);
            OFF_TPTR: reg_val = 32'(trig_ptr_q);
            OFF_CNT:  reg_val = sample_cnt_q;
            default:  reg_val = 32'd0;
         endcase
      end
   end

   // Stage 1 alongside the RAM read, stage 2 selects between RAM and registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_buf_q   <= 1'b0;
         rd_reg_q   <= '0;
         lb_data_in <= '0;
      end else begin
         rd_buf_q   <= win && (off[19:15] == OFF_BUF[19:15]) && ((off[14:0] >> aw) == 15'd0);
         rd_reg_q   <= reg_val;
         lb_data_in <= rd_buf_q ? 32'(ram_q) : rd_reg_q;
      end
   end

endmodule

// File: doc/lb_app_capture.md
# lb_app_capture

Application-side localbus peripheral occupying the `lb_addr[23:20]==1` window that the Marble base delegates to external code. It records a stream of samples into a circular buffer with a programmable pre-trigger depth, then freezes on a trigger. The frozen record is read back over the same localbus, delivering `lb_data_in` with the fixed two-cycle alignment that the base's read mux expects.

## Interface
Parameters:
- `aw`, 10: buffer address width; depth N = 2^aw samples
- `dw`, 16: sample width (1..32)

Ports:
- `clk` in 1: the single clock; connects to `lb_clk`; samples share this domain
- `rst` in 1: asynchronous, active-high reset
- `lb_addr` in 24: localbus address
- `lb_strobe` in 1: localbus cycle strobe
- `lb_rd` in 1: 1 = read cycle, 0 = write cycle
- `lb_data_out` in 32: write data
- `lb_data_in` out 32: read data for the address presented two cycles earlier
- `sample_data` in dw: sample word
- `sample_valid` in 1: `sample_data` qualifier
- `trig_ext` in 1: external trigger; rising edge is detected internally
- `busy` out 1: high in ARMED, WAIT_TRIG and POST
- `done` out 1: high in DONE

## Operation
- Address decode is valid only when `lb_addr[23:20]==1` and `lb_addr[16]==1`. The write strobe is `lb_strobe & ~lb_rd`.
- Offset 0x10000, write: control register.
  - bit0: arm
  - bit1: force trigger
  - bit2: clear
  - Bits are pulses; none are stored.
- Offset 0x10001, write: pre-trigger count `ptc`. Bits [aw-1:0] are used; values above N-1 saturate to N-1.
- Read-back registers:
  - 0x10000: status `{28'b0, state[2:0], trig_seen}`
  - 0x10001: `ptc`
  - 0x10002: `trig_ptr` (buffer address written by the trigger sample)
  - 0x10003: total sample count, 32-bit, wraps
- Buffer read-back: offset 0x18000 + i, for i in 0..N-1, returns `mem[(trig_ptr - ptc + i) mod N]`, zero-extended. Address arithmetic is aw-bit modular.
- Unmapped reads return 0.
- State machine:
  - IDLE → ARMED on arm. On entry, `wptr`=0 and `fill`=0.
  - ARMED: each `sample_valid` writes `mem[wptr]` and advances `wptr` (wraps at N) and `fill`. When `fill==ptc` (immediately if `ptc`=0), go to WAIT_TRIG.
  - WAIT_TRIG: keep writing samples. On trigger event (`trig_ext` rising edge or force bit): latch `trig_ptr` = the address of the sample written in that cycle if `sample_valid`, else of the next valid sample; set `post = N - ptc`; go to POST.
  - POST: each valid sample writes and decrements `post`. When `post` reaches 0, go to DONE.
  - DONE: writes are inhibited; the buffer stays frozen until arm or clear.
- Trigger events in IDLE, ARMED, POST or DONE are ignored. `trig_seen` is set only by a trigger accepted in WAIT_TRIG.
- Arm in any state restarts at ARMED.
- Clear → IDLE from any state. Clear beats arm when both are written in the same cycle.
- Writing `ptc` while `busy` takes effect at the next arm.

## Timing
- Reset values: `lb_data_in`=0, `busy`=0, `done`=0; state IDLE; `wptr`, `ptc`, `trig_ptr`, counters and the edge detector all 0. Buffer contents are undefined.
- Read latency: address sampled at cycle t gives `lb_data_in` at t+2, fully pipelined with one read per cycle.
  - Stage 1: register address decode and the buffer RAM read.
  - Stage 2: register the mux output.
- Control writes take effect on the next edge, so state is visible in status 3 cycles after the write strobe.
- `trig_ext` edge detect uses one flop. A pulse of at least one cycle is accepted, with 1 cycle of latency to the state change.
- A buffer write and a read of the same address in the same cycle return the old data (read-first).
- Reset asserted mid-capture returns immediately to IDLE and drops `busy`.

## Structure
- Shared constants file: register offsets (0x10000–0x10003, 0x18000), control bit positions, state encodings (IDLE=0, ARMED=1, WAIT_TRIG=2, POST=3, DONE=4).
- One sub-module: the team's existing `dpram` (aw × dw, one write port, one registered read port) used as the sample buffer. The FSM, pointers and localbus pipeline live in the top module.

## Test plan
- Reset, then read 0x10000 → 0 at t+2 with `busy`=0. Read an unmapped address → 0.
- aw=4, `ptc`=4, arm, ramp samples 0,1,2,… every cycle, force trigger at the sample with value 20:
  - `done` rises after 12 more samples.
  - Reads of 0x18000..0x1800F return 16..31.
  - 0x10002 returns 4 (20 mod 16).
- `ptc`=0, arm, `trig_ext` pulse in the first cycle → record starts at the trigger sample. `ptc`=100 with aw=4 → reads back 15.
- `trig_ext` pulse while ARMED (fill < `ptc`) → ignored, `trig_seen`=0, state stays ARMED/WAIT_TRIG.
- Arm and clear in the same write → state IDLE. Assert `rst` during POST → `busy`=0 next cycle and status reads 0.
- Back-to-back buffer reads on consecutive cycles → each result appears exactly 2 cycles after its address, with no bubbles.
